// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled 8N1 serial receiver feeding a small
// first-word-fall-through FIFO. The consumer sees r_data whenever rx_empty
// is low and removes the head byte by pulsing rd_uart for one clock.
// Handshake: a byte is taken on a rising clk edge when rd_uart = 1 and
// rx_empty = 0; rd_uart while empty has no effect.
module uart_rx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 651,
    parameter int DVSR_W  = 10,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);

    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 1 << FIFO_W;
    localparam int CW    = FIFO_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic              rx_meta;
    logic              rxs;
    logic [DVSR_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        state;
    logic [3:0]        s;
    logic [N_W-1:0]    n;
    logic [DBIT-1:0]   b;
    logic              stop_end;
    logic              rx_done;
    logic              frame_bad;

    logic [DBIT-1:0]   mem [0:DEPTH-1];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic [FIFO_W:0]   count;
    logic [FIFO_W:0]   count_next;
    logic              push;
    logic              pop;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Free-running oversampling tick divider, never realigned to frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == DVSR_W'(DVSR - 1));

    // The frame ends on the last stop-bit tick; the line level decides
    // between a good byte and a framing error.
    assign stop_end  = (state == STOP) && tick && (s == 4'(SB_TICK - 1));
    assign rx_done   = stop_end && rxs;
    assign frame_bad = stop_end && !rxs;

    // Receiver state machine: start detect, mid-bit data sampling, stop check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == 4'd7) begin
                            if (!rxs) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            s <= '0;
                            b <= {rxs, b[DBIT-1:1]};
                            if (n == N_W'(DBIT - 1)) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == 4'(SB_TICK - 1)) begin
                            state <= IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A pop on the same clock frees the slot, so a full FIFO still accepts.
    assign push = rx_done && (!rx_full || rd_uart);
    assign pop  = rd_uart && !rx_empty;

    // Occupancy after this clock's push/pop.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers, count, registered flags and the one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rx_empty  <= 1'b1;
            rx_full   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            rx_empty  <= (count_next == '0);
            rx_full   <= (count_next == CW'(DEPTH));
            frame_err <= frame_bad;
            overrun   <= rx_done && rx_full && !rd_uart;
        end
    end

    // Storage array; contents need no reset because rx_empty guards r_data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= b;
        end
    end

    assign r_data = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives 8N1 frames at 64 clocks per bit (DVSR = 4)
// and compares FIFO behaviour against a byte-queue reference model.
module tb_uart_rx_fifo;

    localparam int DVSR       = 4;
    localparam int BIT_CLKS   = 16 * DVSR;
    localparam int FRAME_CLKS = 10 * BIT_CLKS + 48;
    localparam int DEPTH      = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rd_uart;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int total;
    int bad;
    int cyc;

    logic [7:0] exp_q[$];
    int         exp_ferr;
    int         exp_ovr;

    // Per-frame observations filled in by send_frame.
    int         empty_fall_i;
    int         full_rise_i;
    int         ferr_cnt;
    int         ovr_cnt;
    int         full_low_cnt;
    logic [7:0] rdata_at_fall;
    logic [7:0] rd_data_seen;
    logic       post_rst_empty;
    logic       post_rst_full;
    logic       post_rst_ferr;
    logic       post_rst_ovr;

    uart_rx_fifo #(
        .DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_W(2), .FIFO_W(2)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_uart(rd_uart),
        .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
        .frame_err(frame_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one call per completed frame.
    function automatic void model_frame(input logic [7:0] d, input logic stop_val);
        exp_ferr = 0;
        exp_ovr  = 0;
        if (!stop_val) begin
            exp_ferr = 1;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
        end else begin
            exp_ovr = 1;
        end
    endfunction

    // Drives one frame clock by clock, recording what the outputs do.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input int rd_at, input int rst_at);
        logic prev_empty;
        logic prev_full;
        int   bitn;
        @(negedge clk);
        while (cyc % DVSR != 0) @(negedge clk);
        empty_fall_i = -1;
        full_rise_i  = -1;
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        full_low_cnt = 0;
        prev_empty   = rx_empty;
        prev_full    = rx_full;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            if (i > 0) @(negedge clk);
            if (prev_empty && !rx_empty && empty_fall_i < 0) begin
                empty_fall_i  = i;
                rdata_at_fall = r_data;
            end
            if (!prev_full && rx_full && full_rise_i < 0) full_rise_i = i;
            if (!rx_full) full_low_cnt++;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rst_at >= 0 && i == rst_at + 1) begin
                post_rst_empty = rx_empty;
                post_rst_full  = rx_full;
                post_rst_ferr  = frame_err;
                post_rst_ovr   = overrun;
            end
            prev_empty = rx_empty;
            prev_full  = rx_full;
            bitn = i / BIT_CLKS;
            if (bitn == 0) rx = 1'b0;
            else if (bitn <= 8) rx = data[bitn-1];
            else if (bitn == 9) rx = stop_val;
            else rx = 1'b1;
            if (i == rd_at) rd_data_seen = r_data;
            rd_uart = (i == rd_at);
            rst     = (i == rst_at);
        end
        @(negedge clk);
        rx      = 1'b1;
        rd_uart = 1'b0;
        rst     = 1'b0;
    endtask

    // Samples the head at the current falling edge and requests one pop;
    // returns at the next falling edge with rd_uart still high.
    task automatic pop_one(output logic [7:0] got, output logic was_empty);
        got       = r_data;
        was_empty = rx_empty;
        rd_uart   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rd_uart = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (rx_empty !== 1'b1 || rx_full !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got empty=%b full=%b ferr=%b ovr=%b expected 1 0 0 0",
                     rx_empty, rx_full, frame_err, overrun);
        end
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_single_byte();
        logic [7:0] got;
        logic       emp;
        send_frame(8'hA5, 1'b1, -1, -1);
        model_frame(8'hA5, 1'b1);
        total++;
        if (empty_fall_i < 600 || empty_fall_i > 620) begin
            bad++;
            $display("FAIL single_latency: got %0d clocks expected 600..620", empty_fall_i);
        end
        total++;
        if (rdata_at_fall !== 8'hA5) begin
            bad++;
            $display("FAIL single_data_at_fall: got %h expected a5", rdata_at_fall);
        end
        total++;
        if (ferr_cnt != 0 || ovr_cnt != 0) begin
            bad++;
            $display("FAIL single_pulses: got ferr=%0d ovr=%0d expected 0 0", ferr_cnt, ovr_cnt);
        end
        pop_one(got, emp);
        rd_uart = 1'b0;
        void'(exp_q.pop_front());
        total++;
        if (emp !== 1'b0 || got !== 8'hA5 || rx_empty !== 1'b1) begin
            bad++;
            $display("FAIL single_pop: got data=%h empty_before=%b empty_after=%b expected a5 0 1",
                     got, emp, rx_empty);
        end
    endtask

    task automatic test_fill_overrun();
        logic [7:0] got;
        logic       emp;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, -1, -1);
            model_frame(8'(k), 1'b1);
            total++;
            if (ovr_cnt != exp_ovr || rx_full !== (exp_q.size() == DEPTH)) begin
                bad++;
                $display("FAIL fill_byte%0d: got ovr=%0d full=%b expected ovr=%0d full=%b",
                         k, ovr_cnt, rx_full, exp_ovr, exp_q.size() == DEPTH);
            end
        end
        while (exp_q.size() > 0) begin
            pop_one(got, emp);
            total++;
            if (emp !== 1'b0 || got !== exp_q[0]) begin
                bad++;
                $display("FAIL fill_drain: got data=%h empty=%b expected %h 0", got, emp, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        rd_uart = 1'b0;
        total++;
        if (rx_empty !== 1'b1 || rx_full !== 1'b0) begin
            bad++;
            $display("FAIL fill_empty_after: got empty=%b full=%b expected 1 0", rx_empty, rx_full);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] got;
        logic       emp;
        int         d;
        for (int k = 0; k < 4; k++) begin
            send_frame(8'(8'h10 + k), 1'b1, -1, -1);
            model_frame(8'(8'h10 + k), 1'b1);
        end
        // The fourth frame's rx_full rise marks where rx_done lands for a
        // frame started at the same divider phase.
        d = full_rise_i;
        total++;
        if (d < 600 || d > 620 || rx_full !== 1'b1) begin
            bad++;
            $display("FAIL ppf_full_rise: got clock=%0d full=%b expected 600..620 1", d, rx_full);
        end
        send_frame(8'h77, 1'b1, d - 1, -1);
        total++;
        if (rd_data_seen !== exp_q[0]) begin
            bad++;
            $display("FAIL ppf_pop_head: got %h expected %h", rd_data_seen, exp_q[0]);
        end
        void'(exp_q.pop_front());
        model_frame(8'h77, 1'b1);
        total++;
        if (ovr_cnt != exp_ovr || full_low_cnt != 0 || rx_full !== 1'b1) begin
            bad++;
            $display("FAIL ppf_no_overrun: got ovr=%0d full_low=%0d full=%b expected %0d 0 1",
                     ovr_cnt, full_low_cnt, rx_full, exp_ovr);
        end
        while (exp_q.size() > 0) begin
            pop_one(got, emp);
            total++;
            if (emp !== 1'b0 || got !== exp_q[0]) begin
                bad++;
                $display("FAIL ppf_drain: got data=%h empty=%b expected %h 0", got, emp, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        rd_uart = 1'b0;
        total++;
        if (rx_empty !== 1'b1) begin
            bad++;
            $display("FAIL ppf_empty_after: got %b expected 1", rx_empty);
        end
    endtask

    task automatic test_framing();
        logic [7:0] got;
        logic       emp;
        send_frame(8'h3C, 1'b0, -1, -1);
        model_frame(8'h3C, 1'b0);
        total++;
        if (ferr_cnt != exp_ferr || empty_fall_i != -1 || rx_empty !== 1'b1) begin
            bad++;
            $display("FAIL framing_bad: got ferr=%0d fall=%0d empty=%b expected %0d -1 1",
                     ferr_cnt, empty_fall_i, rx_empty, exp_ferr);
        end
        send_frame(8'h3D, 1'b1, -1, -1);
        model_frame(8'h3D, 1'b1);
        pop_one(got, emp);
        rd_uart = 1'b0;
        total++;
        if (ferr_cnt != 0 || emp !== 1'b0 || got !== exp_q[0]) begin
            bad++;
            $display("FAIL framing_next: got ferr=%0d data=%h empty=%b expected 0 %h 0",
                     ferr_cnt, got, emp, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_glitch();
        int nonempty;
        int ferr;
        nonempty = 0;
        ferr     = 0;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if (i > 0) @(negedge clk);
            if (!rx_empty) nonempty++;
            if (frame_err) ferr++;
            rx = (i < 3 * DVSR) ? 1'b0 : 1'b1;
        end
        total++;
        if (nonempty != 0 || ferr != 0) begin
            bad++;
            $display("FAIL glitch: got nonempty=%0d ferr=%0d expected 0 0", nonempty, ferr);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        logic       emp;
        send_frame(8'h55, 1'b1, -1, -1);
        model_frame(8'h55, 1'b1);
        send_frame(8'hFF, 1'b1, -1, 5 * BIT_CLKS + 30);
        exp_q.delete();
        total++;
        if (post_rst_empty !== 1'b1 || post_rst_full !== 1'b0 || post_rst_ferr !== 1'b0 ||
            post_rst_ovr !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got empty=%b full=%b ferr=%b ovr=%b expected 1 0 0 0",
                     post_rst_empty, post_rst_full, post_rst_ferr, post_rst_ovr);
        end
        total++;
        if (rx_empty !== 1'b1 || ferr_cnt != 0) begin
            bad++;
            $display("FAIL rst_mid_abandon: got empty=%b ferr=%0d expected 1 0", rx_empty, ferr_cnt);
        end
        send_frame(8'h12, 1'b1, -1, -1);
        model_frame(8'h12, 1'b1);
        pop_one(got, emp);
        rd_uart = 1'b0;
        total++;
        if (emp !== 1'b0 || got !== exp_q[0] || rx_empty !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_next: got data=%h empty_before=%b empty_after=%b expected %h 0 1",
                     got, emp, rx_empty, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       sv;
        logic [7:0] got;
        logic       emp;
        int         npop;
        for (int k = 0; k < 10; k++) begin
            d  = 8'($urandom_range(0, 255));
            sv = ($urandom_range(0, 5) != 0);
            send_frame(d, sv, -1, -1);
            model_frame(d, sv);
            total++;
            if (ferr_cnt != exp_ferr || ovr_cnt != exp_ovr || rx_empty !== (exp_q.size() == 0) ||
                rx_full !== (exp_q.size() == DEPTH)) begin
                bad++;
                $display("FAIL rand_frame%0d: got ferr=%0d ovr=%0d empty=%b full=%b expected %0d %0d %b %b",
                         k, ferr_cnt, ovr_cnt, rx_empty, rx_full, exp_ferr, exp_ovr,
                         exp_q.size() == 0, exp_q.size() == DEPTH);
            end
            npop = $urandom_range(0, exp_q.size());
            for (int p = 0; p < npop; p++) begin
                pop_one(got, emp);
                total++;
                if (emp !== 1'b0 || got !== exp_q[0]) begin
                    bad++;
                    $display("FAIL rand_pop: got data=%h empty=%b expected %h 0", got, emp, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            rd_uart = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        test_reset();
        test_single_byte();
        test_fill_overrun();
        test_push_pop_full();
        test_framing();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
